// File: rtl/i2c_slave_capture.sv
// I2C target that ACKs one 7-bit address and captures written bytes into a 16-bit word.
// Reads return the captured word, high byte first, alternating per byte.
// SCL/SDA are oversampled on HCLK; the SDA drive is open-drain and registered.
`timescale 1ns/1ps
module i2c_slave_capture #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        scl,
    inout  wire         sda,
    output logic [15:0] i2c_data,
    output logic        data_valid
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StIgnore
    } state_e;

    // [0] first sync flop, [1] synchronized value, [2] history for edge detection
    logic [2:0]  scl_sync_q;
    logic [2:0]  sda_sync_q;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        oe_q, oe_d;
    logic        first_q, first_d;
    logic        sel_q, sel_d;
    logic        rw_q, rw_d;
    // Second-phase marker: ACK drive in progress, or master ACK seen in RD_ACK
    logic        phase_q, phase_d;

    logic        scl_rise, scl_fall, start_det, stop_det, sda_in;
    logic [7:0]  rx_byte;
    logic [7:0]  rd_byte;

    // Open drain: only ever pull low or release
    assign sda        = oe_q ? 1'b0 : 1'bz;
    assign i2c_data   = data_q;
    assign data_valid = valid_q;

    assign sda_in    = sda_sync_q[1];
    assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
    assign start_det = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
    assign stop_det  = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];

    // Bus input synchronizers; idle bus level is high
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl};
            sda_sync_q <= {sda_sync_q[1:0], sda};
        end
    end

    // FSM and datapath registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= StIdle;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            tx_q      <= 8'h00;
            data_q    <= 16'h0000;
            valid_q   <= 1'b0;
            oe_q      <= 1'b0;
            first_q   <= 1'b0;
            sel_q     <= 1'b0;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            oe_q      <= oe_d;
            first_q   <= first_d;
            sel_q     <= sel_d;
            rw_q      <= rw_d;
            phase_q   <= phase_d;
        end
    end

    // Next-state logic; START/STOP take priority over every state
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        oe_d      = oe_q;
        first_d   = first_q;
        sel_d     = sel_q;
        rw_d      = rw_q;
        phase_d   = phase_q;
        rx_byte   = {shift_q[6:0], sda_in};
        rd_byte   = sel_q ? data_q[7:0] : data_q[15:8];

        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 4'd0;
            first_d   = 1'b1;
            sel_d     = 1'b0;
            oe_d      = 1'b0;
            phase_d   = 1'b0;
        end else if (stop_det) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StIgnore: begin
                end
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rw_d    = rx_byte[0];
                            phase_d = 1'b0;
                            state_d = (rx_byte[7:1] == SLAVE_ADDR) ? StAddrAck : StIgnore;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            oe_d    = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (rw_q) begin
                                // First read bit goes out on the same falling edge
                                state_d = StRdData;
                                tx_d    = rd_byte;
                                oe_d    = ~rd_byte[7];
                                sel_d   = ~sel_q;
                            end else begin
                                state_d = StWrData;
                                oe_d    = 1'b0;
                            end
                        end
                    end
                end
                StWrData: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            data_d  = first_q ? {8'h00, rx_byte} : {data_q[7:0], rx_byte};
                            valid_d = 1'b1;
                            first_d = 1'b0;
                            phase_d = 1'b0;
                            state_d = StWrAck;
                        end
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            oe_d    = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            phase_d   = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = StWrData;
                        end
                    end
                end
                StRdData: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            phase_d = 1'b0;
                            state_d = StRdAck;
                        end else begin
                            oe_d = ~tx_q[6];
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        if (sda_in) begin
                            state_d = StIgnore;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d   = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = StRdData;
                        tx_d      = rd_byte;
                        oe_d      = ~rd_byte[7];
                        sel_d     = ~sel_q;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_capture.sv
// Bench for i2c_slave_capture: bit-banged I2C master, word-level reference model,
// and a scoreboard that checks captured words and read-back bytes as they appear.
`timescale 1ns/1ps
module tb_i2c_slave_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        m_sda_low = 1'b0;
    wire         sda_bus;
    logic [15:0] i2c_data;
    logic        data_valid;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  act_rd[$];
    logic [15:0] model_word = 16'h0000;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_capture #(.SLAVE_ADDR(7'h50)) dut (
        .HCLK       (clk),
        .HRESETn    (rst_n),
        .scl        (scl),
        .sda        (sda_bus),
        .i2c_data   (i2c_data),
        .data_valid (data_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Scoreboard monitor: compares whenever the DUT pulses data_valid or a read byte lands
    always @(negedge clk) begin
        if (rst_n && data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_data_valid: got word %0h, expected no pulse", i2c_data);
            end else begin
                chk("capture_word", {16'h0, i2c_data}, {16'h0, exp_q.pop_front()});
            end
        end
        if (act_rd.size() > 0) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read_byte: got %0h, expected none", act_rd.pop_front());
            end else begin
                chk("read_byte", {24'h0, act_rd.pop_front()}, {24'h0, exp_rd.pop_front()});
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        m_sda_low = ~b;
        tick(4);
        scl = 1'b1;
        tick(8);
        scl = 1'b0;
        tick(4);
    endtask

    task automatic sample_bit(output logic b);
        m_sda_low = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(4);
        @(negedge clk);
        b = sda_bus;
        tick(4);
        scl = 1'b0;
        tick(4);
    endtask

    // Works from idle bus or as repeated START with SCL low
    task automatic start_cond();
        m_sda_low = 1'b0;
        tick(4);
        scl = 1'b1;
        tick(4);
        m_sda_low = 1'b1;
        tick(4);
        scl = 1'b0;
        tick(4);
    endtask

    task automatic stop_cond();
        m_sda_low = 1'b1;
        tick(4);
        scl = 1'b1;
        tick(4);
        m_sda_low = 1'b0;
        tick(8);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) drive_bit(b[i]);
        sample_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic nack);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            sample_bit(bit_v);
            b[i] = bit_v;
        end
        drive_bit(nack);
    endtask

    // Write wr[] to addr, then optionally repeated-START read n_rd bytes (last one NACKed)
    task automatic do_txn(input logic [6:0] addr, input logic [7:0] wr[$], input int n_rd);
        logic       ack;
        logic       hit;
        logic [7:0] v;
        hit = (addr == 7'h50);
        start_cond();
        send_byte({addr, 1'b0}, ack);
        chk("wr_addr_ack", {31'h0, ack}, {31'h0, ~hit});
        for (int k = 0; k < wr.size(); k++) begin
            if (hit) begin
                model_word = (k == 0) ? {8'h00, wr[k]} : {model_word[7:0], wr[k]};
                exp_q.push_back(model_word);
            end
            send_byte(wr[k], ack);
            chk("wr_data_ack", {31'h0, ack}, {31'h0, ~hit});
        end
        if (n_rd > 0) begin
            start_cond();
            send_byte({addr, 1'b1}, ack);
            chk("rd_addr_ack", {31'h0, ack}, {31'h0, ~hit});
            if (hit) begin
                for (int r = 0; r < n_rd; r++) begin
                    exp_rd.push_back((r % 2 == 0) ? model_word[15:8] : model_word[7:0]);
                    recv_byte(v, r == n_rd - 1);
                    act_rd.push_back(v);
                end
                @(negedge clk);
                chk("sda_released_after_nack", {31'h0, sda_bus}, 32'h1);
            end
        end
        stop_cond();
    endtask

    initial begin
        logic [7:0] q[$];
        logic [6:0] a;
        logic       ack;
        int         n_wr;
        int         n_rd;

        // Reset state
        rst_n = 1'b0;
        tick(5);
        @(negedge clk);
        chk("reset_data", {16'h0, i2c_data}, 32'h0);
        chk("reset_valid", {31'h0, data_valid}, 32'h0);
        chk("reset_sda", {31'h0, sda_bus}, 32'h1);
        rst_n = 1'b1;
        tick(5);

        // Single byte write
        q.delete();
        q.push_back(8'h45);
        do_txn(7'h50, q, 0);
        chk("word_single_byte", {16'h0, i2c_data}, 32'h0045);

        // Three bytes keep the last two
        q.delete();
        q.push_back(8'h12);
        q.push_back(8'h34);
        q.push_back(8'h56);
        do_txn(7'h50, q, 0);
        chk("word_three_bytes", {16'h0, i2c_data}, 32'h3456);

        // Wrong address is NACKed and ignored
        q.delete();
        q.push_back(8'hAA);
        do_txn(7'h51, q, 0);
        chk("word_after_wrong_addr", {16'h0, i2c_data}, 32'h3456);

        // Write then repeated-START read of three bytes
        q.delete();
        q.push_back(8'h12);
        q.push_back(8'h34);
        do_txn(7'h50, q, 3);

        // Reset asserted while the target drives the write ACK
        start_cond();
        send_byte({7'h50, 1'b0}, ack);
        chk("rst_case_addr_ack", {31'h0, ack}, 32'h0);
        model_word = 16'h00C3;
        exp_q.push_back(model_word);
        for (int i = 7; i >= 0; i--) drive_bit(model_word[i]);
        m_sda_low = 1'b0;
        tick(4);
        @(negedge clk);
        chk("wr_ack_driven", {31'h0, sda_bus}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("sda_release_on_reset", {31'h0, sda_bus}, 32'h1);
        chk("data_cleared_on_reset", {16'h0, i2c_data}, 32'h0);
        model_word = 16'h0000;
        tick(4);
        rst_n = 1'b1;
        scl = 1'b1;
        tick(8);

        // Read-only after reset returns the cleared word
        q.delete();
        do_txn(7'h50, q, 2);

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = 7'($urandom);
                if (a == 7'h50) a = 7'h51;
            end else begin
                a = 7'h50;
            end
            n_wr = $urandom_range(0, 4);
            n_rd = $urandom_range(0, 3);
            q.delete();
            for (int k = 0; k < n_wr; k++) q.push_back(8'($urandom));
            do_txn(a, q, n_rd);
        end

        tick(20);
        chk("pending_captures", exp_q.size(), 32'h0);
        chk("pending_reads", exp_rd.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
